// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for pipeline stage registers
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_payload_t;

    localparam logic [31:0]    NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0]    NOP_PC    = 32'h0000_0000;
    localparam if_id_payload_t IF_ID_NOP = '{pc: NOP_PC, instr: NOP_INSTR};

    // State encoding is chosen so that it equals the number of held entries.
    function automatic logic [1:0] state_occupancy(stage_state_e s);
        return 2'(s);
    endfunction

endpackage

// File: rtl/pipe_stage_skid_reg_if.sv
// rtl/pipe_stage_skid_reg_if.sv - upstream/downstream valid-ready handshake bundle
interface pipe_stage_skid_reg_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with enable and synchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/pipe_stage_skid_reg.sv
// rtl/pipe_stage_skid_reg.sv - valid/ready pipeline register with optional skid entry
module pipe_stage_skid_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
    parameter int                SKID_EN   = 1,
    parameter int                CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  freeze,
    pipe_stage_skid_reg_if.slave  bus,
    output logic [1:0]            occupancy,
    output logic [CNT_W-1:0]      stall_cnt
);
    stage_state_e      state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;

    logic in_ready;
    logic out_valid;
    logic in_fire;
    logic out_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // main_q is forced back to NOP_VALUE whenever the stage drains, so out_data
    // needs no output mux.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = NOP_VALUE;
            skid_d  = NOP_VALUE;
        end else if (!freeze) begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_FULL;
                        main_d  = bus.in_data;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        main_d = bus.in_data;
                    end else if (in_fire) begin
                        state_d = ST_SKID;
                        skid_d  = bus.in_data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                        main_d  = NOP_VALUE;
                    end
                end
                ST_SKID: begin
                    if (out_fire) begin
                        state_d = ST_FULL;
                        main_d  = skid_q;
                        skid_d  = NOP_VALUE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = NOP_VALUE;
                    skid_d  = NOP_VALUE;
                end
            endcase
        end
    end

    // With the skid entry, in_ready depends only on state and freeze, which
    // keeps out_ready off the upstream timing path.
    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        if (freeze) begin
            in_ready = 1'b0;
        end else if (SKID_EN != 0) begin
            in_ready = (state_q != ST_SKID);
        end else begin
            in_ready = !out_valid || bus.out_ready;
        end
        in_fire  = bus.in_valid && in_ready;
        out_fire = out_valid && bus.out_ready && !freeze;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = main_q;
    assign occupancy     = state_occupancy(state_q);

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .en  (out_valid && !bus.out_ready && !freeze),
        .clr (1'b0),
        .cnt (stall_cnt)
    );
endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb/tb_pipe_stage_skid_reg.sv - randomized and directed bench for pipe_stage_skid_reg
module tb_pipe_stage_skid_reg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_flush = 1'b0, a_freeze = 1'b0;
    logic b_flush = 1'b0, b_freeze = 1'b0;
    logic [1:0]  a_occ, b_occ;
    logic [15:0] a_stall;
    logic [3:0]  b_stall;

    always #5 clk = ~clk;

    pipe_stage_skid_reg_if #(.DATA_W(64)) a_if();
    pipe_stage_skid_reg_if #(.DATA_W(16)) b_if();

    pipe_stage_skid_reg #(.DATA_W(64), .SKID_EN(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .flush(a_flush), .freeze(a_freeze),
        .bus(a_if), .occupancy(a_occ), .stall_cnt(a_stall)
    );

    pipe_stage_skid_reg #(.DATA_W(16), .SKID_EN(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush), .freeze(b_freeze),
        .bus(b_if), .occupancy(b_occ), .stall_cnt(b_stall)
    );

    int total = 0;
    int bad   = 0;

    // Reference: each stage is a bounded FIFO of accepted beats.
    logic [63:0] ma_q[$];
    logic [63:0] mb_q[$];
    int ma_stall = 0;
    int mb_stall = 0;
    bit a_fi, a_fo, b_fi, b_fo;

    function automatic bit ma_ready();
        return !a_freeze && (ma_q.size() < 2);
    endfunction

    function automatic bit mb_ready();
        return !b_freeze && ((mb_q.size() == 0) || b_if.out_ready);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma_q.delete();
            mb_q.delete();
            ma_stall = 0;
            mb_stall = 0;
        end else begin
            if (ma_q.size() > 0 && !a_if.out_ready && !a_freeze && ma_stall < 65535) ma_stall++;
            if (mb_q.size() > 0 && !b_if.out_ready && !b_freeze && mb_stall < 15) mb_stall++;
            if (a_flush) begin
                ma_q.delete();
            end else if (!a_freeze) begin
                a_fi = a_if.in_valid && ma_ready();
                a_fo = (ma_q.size() > 0) && a_if.out_ready;
                if (a_fo) void'(ma_q.pop_front());
                if (a_fi) ma_q.push_back(a_if.in_data);
            end
            if (b_flush) begin
                mb_q.delete();
            end else if (!b_freeze) begin
                b_fi = b_if.in_valid && mb_ready();
                b_fo = (mb_q.size() > 0) && b_if.out_ready;
                if (b_fo) void'(mb_q.pop_front());
                if (b_fi) mb_q.push_back({48'h0, b_if.in_data});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        rst = 1'b0;
        tick();
        total++; if (a_if.out_valid !== 1'b0) begin bad++; $display("FAIL rst_a_valid got=%0b want=0", a_if.out_valid); end
        total++; if (a_if.out_data !== 64'h0) begin bad++; $display("FAIL rst_a_data got=%0h want=0", a_if.out_data); end
        total++; if (a_if.in_ready !== 1'b1) begin bad++; $display("FAIL rst_a_ready got=%0b want=1", a_if.in_ready); end
        total++; if (b_if.in_ready !== 1'b1) begin bad++; $display("FAIL rst_b_ready got=%0b want=1", b_if.in_ready); end
        a_if.out_ready = 1'b0;
        a_if.in_valid  = 1'b1;
        a_if.in_data   = 64'hA;
        tick();
        a_if.in_data   = 64'hB;
        tick();
        a_if.in_valid  = 1'b0;
        #1;
        total++; if (a_occ !== 2'd2) begin bad++; $display("FAIL pre_rst_occ got=%0d want=2", a_occ); end
        total++; if (a_if.out_data !== 64'hA) begin bad++; $display("FAIL pre_rst_data got=%0h want=a", a_if.out_data); end
        rst = 1'b1;
        #1;
        total++; if (a_if.out_valid !== 1'b0) begin bad++; $display("FAIL async_rst_valid got=%0b want=0", a_if.out_valid); end
        total++; if (a_if.out_data !== 64'h0) begin bad++; $display("FAIL async_rst_data got=%0h want=0", a_if.out_data); end
        total++; if (a_occ !== 2'd0) begin bad++; $display("FAIL async_rst_occ got=%0d want=0", a_occ); end
        total++; if (a_stall !== 16'd0) begin bad++; $display("FAIL async_rst_stall got=%0d want=0", a_stall); end
        #1;
        rst = 1'b0;
        #1;
        total++; if (a_if.in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%0b want=1", a_if.in_ready); end
        tick();
    endtask

    task automatic test_streaming();
        a_if.out_ready = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            a_if.in_valid = (k <= 8);
            a_if.in_data  = 64'(k);
            #1;
            if (k <= 8) begin
                total++; if (a_if.in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready k=%0d got=%0b want=1", k, a_if.in_ready); end
            end
            if (k > 1) begin
                total++;
                if (a_if.out_valid !== 1'b1 || a_if.out_data !== 64'(k - 1)) begin
                    bad++; $display("FAIL stream_data k=%0d got=%0b/%0h want=1/%0h", k, a_if.out_valid, a_if.out_data, k - 1);
                end
            end
            tick();
        end
        a_if.in_valid = 1'b0;
        #1;
        total++; if (a_if.out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%0b want=0", a_if.out_valid); end
        total++; if (a_stall !== 16'd0) begin bad++; $display("FAIL stream_stall got=%0d want=0", a_stall); end
        tick();
    endtask

    task automatic test_back_pressure();
        logic [63:0] got[$];
        logic [63:0] want [3];
        bit acc;
        want[0] = 64'h10; want[1] = 64'h11; want[2] = 64'h12;
        a_if.out_ready = 1'b0;
        a_if.in_valid  = 1'b1;
        a_if.in_data   = 64'h10;
        tick();
        a_if.in_data   = 64'h11;
        #1;
        total++; if (a_if.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_full got=%0b want=1", a_if.in_ready); end
        tick();
        a_if.in_data = 64'h12;
        #1;
        total++; if (a_occ !== 2'd2) begin bad++; $display("FAIL bp_occ got=%0d want=2", a_occ); end
        total++; if (a_if.in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_skid got=%0b want=0", a_if.in_ready); end
        total++; if (a_if.out_data !== 64'h10) begin bad++; $display("FAIL bp_head got=%0h want=10", a_if.out_data); end
        tick();
        total++; if (a_stall !== 16'd2) begin bad++; $display("FAIL bp_stall_mid got=%0d want=2", a_stall); end
        tick();
        a_if.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (a_if.out_valid) got.push_back(a_if.out_data);
            acc = a_if.in_valid && a_if.in_ready;
            tick();
            if (acc) a_if.in_valid = 1'b0;
        end
        total++; if (got.size() != 3) begin bad++; $display("FAIL bp_count got=%0d want=3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) begin
                total++; if (got[i] !== want[i]) begin bad++; $display("FAIL bp_order i=%0d got=%0h want=%0h", i, got[i], want[i]); end
            end
        end
        total++; if (a_stall !== 16'd3) begin bad++; $display("FAIL bp_stall got=%0d want=3", a_stall); end
    endtask

    task automatic test_flush();
        a_if.out_ready = 1'b0;
        a_if.in_valid  = 1'b1;
        a_if.in_data   = 64'h1A;
        tick();
        a_if.in_data   = 64'h1B;
        tick();
        a_if.in_data   = 64'h20;
        a_flush        = 1'b1;
        #1;
        total++; if (a_occ !== 2'd2) begin bad++; $display("FAIL flush_pre_occ got=%0d want=2", a_occ); end
        tick();
        a_flush       = 1'b0;
        a_if.in_valid = 1'b0;
        #1;
        total++; if (a_if.out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b want=0", a_if.out_valid); end
        total++; if (a_if.out_data !== 64'h0) begin bad++; $display("FAIL flush_data got=%0h want=0", a_if.out_data); end
        total++; if (a_occ !== 2'd0) begin bad++; $display("FAIL flush_occ got=%0d want=0", a_occ); end
        total++; if (a_stall !== 16'd5) begin bad++; $display("FAIL flush_stall got=%0d want=5", a_stall); end
        a_if.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (a_if.out_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost i=%0d got=%0b/%0h want=0", i, a_if.out_valid, a_if.out_data); end
        end
    endtask

    task automatic test_freeze();
        a_if.out_ready = 1'b0;
        a_if.in_valid  = 1'b1;
        a_if.in_data   = 64'h30;
        tick();
        a_if.in_data   = 64'h31;
        a_if.out_ready = 1'b1;
        a_freeze       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (a_if.in_ready !== 1'b0) begin bad++; $display("FAIL frz_ready i=%0d got=%0b want=0", i, a_if.in_ready); end
            total++;
            if (a_if.out_valid !== 1'b1 || a_if.out_data !== 64'h30) begin
                bad++; $display("FAIL frz_hold i=%0d got=%0b/%0h want=1/30", i, a_if.out_valid, a_if.out_data);
            end
            total++; if (a_stall !== 16'd5) begin bad++; $display("FAIL frz_stall i=%0d got=%0d want=5", i, a_stall); end
            tick();
        end
        a_freeze      = 1'b0;
        a_if.in_valid = 1'b0;
        #1;
        total++; if (a_if.out_data !== 64'h30) begin bad++; $display("FAIL frz_release got=%0h want=30", a_if.out_data); end
        tick();
        total++; if (a_if.out_valid !== 1'b0) begin bad++; $display("FAIL frz_fired got=%0b want=0", a_if.out_valid); end
    endtask

    task automatic test_no_skid_saturate();
        b_if.out_ready = 1'b0;
        b_if.in_valid  = 1'b1;
        b_if.in_data   = 16'h40;
        #1;
        total++; if (b_if.in_ready !== 1'b1) begin bad++; $display("FAIL ns_ready_empty got=%0b want=1", b_if.in_ready); end
        tick();
        b_if.in_data = 16'h41;
        for (int i = 0; i < 20; i++) begin
            #1;
            total++; if (b_if.in_ready !== 1'b0) begin bad++; $display("FAIL ns_ready i=%0d got=%0b want=0", i, b_if.in_ready); end
            total++; if (b_occ !== 2'd1) begin bad++; $display("FAIL ns_occ i=%0d got=%0d want=1", i, b_occ); end
            total++; if (int'(b_stall) != (i < 15 ? i : 15)) begin bad++; $display("FAIL ns_stall i=%0d got=%0d want=%0d", i, b_stall, (i < 15 ? i : 15)); end
            tick();
        end
        total++; if (b_stall !== 4'd15) begin bad++; $display("FAIL ns_sat got=%0d want=15", b_stall); end
        b_if.out_ready = 1'b1;
        #1;
        total++; if (b_if.in_ready !== 1'b1 || b_if.out_data !== 16'h40) begin bad++; $display("FAIL ns_release got=%0b/%0h want=1/40", b_if.in_ready, b_if.out_data); end
        tick();
        b_if.in_valid = 1'b0;
        #1;
        total++; if (b_if.out_valid !== 1'b1 || b_if.out_data !== 16'h41) begin bad++; $display("FAIL ns_reload got=%0b/%0h want=1/41", b_if.out_valid, b_if.out_data); end
        tick();
        total++; if (b_if.out_valid !== 1'b0) begin bad++; $display("FAIL ns_drain got=%0b want=0", b_if.out_valid); end
        total++; if (b_stall !== 4'd15) begin bad++; $display("FAIL ns_sat_hold got=%0d want=15", b_stall); end
    endtask

    task automatic test_random();
        logic [63:0] ea, eb;
        for (int c = 0; c < 400; c++) begin
            a_if.in_valid  = 1'($urandom_range(0, 1));
            a_if.in_data   = {$urandom, $urandom};
            a_if.out_ready = ($urandom_range(0, 3) != 0);
            a_freeze       = ($urandom_range(0, 9) == 0);
            a_flush        = ($urandom_range(0, 24) == 0);
            b_if.in_valid  = 1'($urandom_range(0, 1));
            b_if.in_data   = 16'($urandom);
            b_if.out_ready = ($urandom_range(0, 2) != 0);
            b_freeze       = ($urandom_range(0, 9) == 0);
            b_flush        = ($urandom_range(0, 24) == 0);
            #1;
            ea = (ma_q.size() > 0) ? ma_q[0] : 64'h0;
            eb = (mb_q.size() > 0) ? mb_q[0] : 64'h0;
            total++; if (a_if.in_ready !== ma_ready()) begin bad++; $display("FAIL rnd_a_ready c=%0d got=%0b want=%0b", c, a_if.in_ready, ma_ready()); end
            total++;
            if (a_if.out_valid !== (ma_q.size() > 0) || a_if.out_data !== ea) begin
                bad++; $display("FAIL rnd_a_out c=%0d got=%0b/%0h want=%0b/%0h", c, a_if.out_valid, a_if.out_data, ma_q.size() > 0, ea);
            end
            total++; if (int'(a_occ) != ma_q.size()) begin bad++; $display("FAIL rnd_a_occ c=%0d got=%0d want=%0d", c, a_occ, ma_q.size()); end
            total++; if (int'(a_stall) != ma_stall) begin bad++; $display("FAIL rnd_a_stall c=%0d got=%0d want=%0d", c, a_stall, ma_stall); end
            total++; if (b_if.in_ready !== mb_ready()) begin bad++; $display("FAIL rnd_b_ready c=%0d got=%0b want=%0b", c, b_if.in_ready, mb_ready()); end
            total++;
            if (b_if.out_valid !== (mb_q.size() > 0) || {48'h0, b_if.out_data} !== eb) begin
                bad++; $display("FAIL rnd_b_out c=%0d got=%0b/%0h want=%0b/%0h", c, b_if.out_valid, b_if.out_data, mb_q.size() > 0, eb);
            end
            total++; if (int'(b_occ) != mb_q.size()) begin bad++; $display("FAIL rnd_b_occ c=%0d got=%0d want=%0d", c, b_occ, mb_q.size()); end
            total++; if (int'(b_stall) != mb_stall) begin bad++; $display("FAIL rnd_b_stall c=%0d got=%0d want=%0d", c, b_stall, mb_stall); end
            tick();
        end
        a_flush = 1'b0; a_freeze = 1'b0; a_if.in_valid = 1'b0;
        b_flush = 1'b0; b_freeze = 1'b0; b_if.in_valid = 1'b0;
    endtask

    initial begin
        a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.out_ready = 1'b0;
        b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.out_ready = 1'b0;
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_freeze();
        test_no_skid_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
